// File: rtl/airi5c_trng_health.sv
// airi5c_trng_health
// Continuous entropy health monitor placed between the TRNG core and the random-pool FIFO.
// Every 8-bit sample gets a Repetition Count Test (RCT) and an Adaptive Proportion Test
// (APT). A start-up block of samples is tested but discarded. After that, passing samples
// are forwarded. Any failure latches an alarm that blocks output until it is cleared.
//
// Optional feature: define AIRI5C_TRNG_HEALTH_STATS_EN to get a 16-bit saturating count of
// alarm entries on fail_cnt_o. Without it, fail_cnt_o is tied to zero.
//
// Ports:
//   clk          system clock
//   n_reset      asynchronous active-low reset
//   enable_i     monitor enable; low flushes to idle
//   data_i       raw sample from TRNG core
//   valid_i      data_i valid strobe
//   alarm_clr_i  pulse that clears a latched alarm and restarts the start-up block
//   data_o       checked sample (holds its value while valid_o is low)
//   valid_o      checked sample valid, one cycle wide
//   ready_o      start-up complete, monitor forwarding
//   alarm_o      sticky alarm (rct_fail_o | apt_fail_o)
//   rct_fail_o   sticky RCT failure flag
//   apt_fail_o   sticky APT failure flag
//   fail_cnt_o   alarm-entry counter (optional feature)

module airi5c_trng_health #(
  parameter int unsigned RCT_CUTOFF      = 4,
  parameter int unsigned APT_WINDOW      = 512,
  parameter int unsigned APT_CUTOFF      = 13,
  parameter int unsigned STARTUP_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        enable_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        alarm_clr_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        ready_o,
  output logic        alarm_o,
  output logic        rct_fail_o,
  output logic        apt_fail_o,
  output logic [15:0] fail_cnt_o
);

  localparam int unsigned IdxW    = $clog2(APT_WINDOW);
  // One extra bit so a match count equal to the full window length still fits.
  localparam int unsigned AptCntW = IdxW + 1;

  localparam logic [7:0]         RctCut      = 8'(RCT_CUTOFF);
  localparam logic [AptCntW-1:0] AptCut      = AptCntW'(APT_CUTOFF);
  localparam logic [15:0]        StartupLast = 16'(STARTUP_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StStartup, StRun, StAlarm} state_e;

  state_e               state_q;
  logic [15:0]          startup_cnt_q;
  logic [7:0]           rct_last_q;
  logic [7:0]           rct_cnt_q;
  logic [IdxW-1:0]      apt_idx_q;
  logic [7:0]           apt_ref_q;
  logic [AptCntW-1:0]   apt_cnt_q;
  logic                 rct_fail_q;
  logic                 apt_fail_q;
  logic                 ready_q;
  logic                 valid_q;
  logic [7:0]           data_q;

  logic [7:0]           rct_cnt_upd;
  logic [AptCntW-1:0]   apt_cnt_upd;
  logic                 rct_hit;
  logic                 apt_hit;
  logic                 testing;
  logic                 sample_fail;
  logic                 clr_tests;

  // Updated test statistics as they would be after accepting data_i.
  always_comb begin
    rct_cnt_upd = 8'd1;
    // A zero count marks "no previous sample" after a flush or clear.
    if ((rct_cnt_q != 8'd0) && (data_i == rct_last_q)) begin
      rct_cnt_upd = (rct_cnt_q == 8'hFF) ? 8'hFF : rct_cnt_q + 8'd1;
    end

    apt_cnt_upd = AptCntW'(1);
    if (apt_idx_q != '0) begin
      apt_cnt_upd = (data_i == apt_ref_q) ? apt_cnt_q + AptCntW'(1) : apt_cnt_q;
    end

    rct_hit     = (rct_cnt_upd == RctCut);
    apt_hit     = (apt_cnt_upd == AptCut);
    testing     = enable_i & valid_i & ((state_q == StStartup) | (state_q == StRun));
    sample_fail = testing & (rct_hit | apt_hit);
    clr_tests   = ~enable_i | (state_q == StIdle) | ((state_q == StAlarm) & alarm_clr_i);
  end

  // Test state and start-up counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      startup_cnt_q <= 16'd0;
      rct_last_q    <= 8'd0;
      rct_cnt_q     <= 8'd0;
      apt_idx_q     <= '0;
      apt_ref_q     <= 8'd0;
      apt_cnt_q     <= '0;
    end else if (clr_tests) begin
      startup_cnt_q <= 16'd0;
      rct_last_q    <= 8'd0;
      rct_cnt_q     <= 8'd0;
      apt_idx_q     <= '0;
      apt_ref_q     <= 8'd0;
      apt_cnt_q     <= '0;
    end else if (testing) begin
      rct_last_q <= data_i;
      rct_cnt_q  <= rct_cnt_upd;
      apt_idx_q  <= apt_idx_q + IdxW'(1);
      apt_cnt_q  <= apt_cnt_upd;
      if (apt_idx_q == '0) begin
        apt_ref_q <= data_i;
      end
      if ((state_q == StStartup) && !sample_fail) begin
        startup_cnt_q <= startup_cnt_q + 16'd1;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= StIdle;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= StIdle;
        rct_fail_q <= 1'b0;
        apt_fail_q <= 1'b0;
        ready_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StStartup;
          end
          StStartup, StRun: begin
            if (sample_fail) begin
              state_q    <= StAlarm;
              rct_fail_q <= rct_hit;
              apt_fail_q <= apt_hit;
              ready_q    <= 1'b0;
            end else if (valid_i) begin
              if (state_q == StStartup) begin
                if (startup_cnt_q == StartupLast) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
                end
              end else begin
                valid_q <= 1'b1;
                data_q  <= data_i;
              end
            end
          end
          StAlarm: begin
            // A sample arriving with the clear is dropped; tests restart clean.
            if (alarm_clr_i) begin
              state_q    <= StStartup;
              rct_fail_q <= 1'b0;
              apt_fail_q <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

`ifdef AIRI5C_TRNG_HEALTH_STATS_EN
  logic [15:0] fail_cnt_q;

  // Counts alarm entries; survives enable and alarm clears.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      fail_cnt_q <= 16'd0;
    end else if (sample_fail && (fail_cnt_q != 16'hFFFF)) begin
      fail_cnt_q <= fail_cnt_q + 16'd1;
    end
  end

  assign fail_cnt_o = fail_cnt_q;
`else
  assign fail_cnt_o = 16'h0000;
`endif

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign ready_o    = ready_q;
  assign rct_fail_o = rct_fail_q;
  assign apt_fail_o = apt_fail_q;
  assign alarm_o    = rct_fail_q | apt_fail_q;

endmodule
